// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the hazard control unit: forward-select codes and FSM states.
package hazard_ctrl_unit_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int MCNT_W = 4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MDU_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// One forwarding selector: picks the youngest in-flight producer of a source register.
module fwd_sel
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] src_i,
  input  logic [RW-1:0] mem_rw_i,
  input  logic          mem_we_i,
  input  logic [RW-1:0] wb_rw_i,
  input  logic          wb_we_i,
  output logic [1:0]    sel_o
);

  // Register 0 is hardwired, so it is never a forwarding target.
  always_comb begin
    sel_o = FWD_NONE;
    if (src_i != '0) begin
      if (mem_we_i && (src_i == mem_rw_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_we_i && (src_i == wb_rw_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: forwarding selects, load-use/branch stalls, multicycle-unit hold.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int RW      = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RW-1:0]    ID_rs,
  input  logic [RW-1:0]    ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             ID_is_branch,
  input  logic [RW-1:0]    EX_rs,
  input  logic [RW-1:0]    EX_rt,
  input  logic [RW-1:0]    EX_RW,
  input  logic             EX_regwe,
  input  logic             EX_memread,
  input  logic             EX_mdu_start,
  input  logic [RW-1:0]    MEM_rt,
  input  logic [RW-1:0]    MEM_RW,
  input  logic             MEM_regwe,
  input  logic             MEM_memread,
  input  logic             MEM_ramwe,
  input  logic [RW-1:0]    WB_RW,
  input  logic             WB_regwe,
  output logic [1:0]       ID_forwardA,
  output logic [1:0]       ID_forwardB,
  output logic [1:0]       EX_forwardA,
  output logic [1:0]       EX_forwardB,
  output logic             MEM_forward,
  output logic             stall,
  output logic             flush_idex,
  output logic             ex_hold,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e              state_q;
  logic [MCNT_W-1:0]   mcnt_q;
  logic                ex_dep, mem_dep, load_use, branch_haz, hazard;
  logic                busy, release_c, start_c, hazard_ok;

  fwd_sel #(.RW(RW)) u_fwd_id_a (.src_i(ID_rs), .mem_rw_i(MEM_RW), .mem_we_i(MEM_regwe),
                                 .wb_rw_i(WB_RW), .wb_we_i(WB_regwe), .sel_o(ID_forwardA));
  fwd_sel #(.RW(RW)) u_fwd_id_b (.src_i(ID_rt), .mem_rw_i(MEM_RW), .mem_we_i(MEM_regwe),
                                 .wb_rw_i(WB_RW), .wb_we_i(WB_regwe), .sel_o(ID_forwardB));
  fwd_sel #(.RW(RW)) u_fwd_ex_a (.src_i(EX_rs), .mem_rw_i(MEM_RW), .mem_we_i(MEM_regwe),
                                 .wb_rw_i(WB_RW), .wb_we_i(WB_regwe), .sel_o(EX_forwardA));
  fwd_sel #(.RW(RW)) u_fwd_ex_b (.src_i(EX_rt), .mem_rw_i(MEM_RW), .mem_we_i(MEM_regwe),
                                 .wb_rw_i(WB_RW), .wb_we_i(WB_regwe), .sel_o(EX_forwardB));

  assign MEM_forward = WB_regwe & MEM_ramwe & (MEM_rt != '0) & (MEM_rt == WB_RW);

  assign ex_dep  = (EX_RW != '0) &
                   ((ID_use_rs & (ID_rs == EX_RW)) | (ID_use_rt & (ID_rt == EX_RW)));
  assign mem_dep = (MEM_RW != '0) &
                   ((ID_use_rs & (ID_rs == MEM_RW)) | (ID_use_rt & (ID_rt == MEM_RW)));

  assign load_use   = EX_memread & EX_regwe & ex_dep;
  assign branch_haz = ID_is_branch & ((EX_regwe & ex_dep) | (MEM_memread & mem_dep));
  assign hazard     = load_use | branch_haz;

  assign busy      = (state_q == ST_MDU_BUSY);
  assign release_c = busy & (mcnt_q <= MCNT_W'(1));
  assign start_c   = ~busy & EX_mdu_start;
  // Hazards are only honoured when the multicycle unit is not holding EX.
  assign hazard_ok = (~busy | release_c) & hazard;

  // Gated by rst_n so reset silences the controls even while hazard inputs are live.
  assign stall      = rst_n & (start_c | (busy & ~release_c) | hazard_ok);
  assign flush_idex = rst_n & hazard_ok;
  assign ex_hold    = rst_n & (start_c | (busy & ~release_c));
  assign mdu_done   = rst_n & release_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (EX_mdu_start) begin
            state_q <= ST_MDU_BUSY;
            mcnt_q  <= MCNT_W'(MDU_LAT - 1);
          end
        end
        ST_MDU_BUSY: begin
          if (mcnt_q > MCNT_W'(1)) begin
            mcnt_q <= mcnt_q - MCNT_W'(1);
          end else begin
            state_q <= ST_IDLE;
            mcnt_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mcnt_q  <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_idex && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with a cycle-indexed reference model.
module tb_hazard_ctrl_unit;
  localparam int RW      = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [RW-1:0] ID_rs, ID_rt, EX_rs, EX_rt, EX_RW, MEM_rt, MEM_RW, WB_RW;
  logic ID_use_rs, ID_use_rt, ID_is_branch, EX_regwe, EX_memread, EX_mdu_start;
  logic MEM_regwe, MEM_memread, MEM_ramwe, WB_regwe;
  logic [1:0] ID_forwardA, ID_forwardB, EX_forwardA, EX_forwardB;
  logic MEM_forward, stall, flush_idex, ex_hold, mdu_done;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.RW(RW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .ID_is_branch(ID_is_branch),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_RW(EX_RW), .EX_regwe(EX_regwe),
    .EX_memread(EX_memread), .EX_mdu_start(EX_mdu_start),
    .MEM_rt(MEM_rt), .MEM_RW(MEM_RW), .MEM_regwe(MEM_regwe), .MEM_memread(MEM_memread),
    .MEM_ramwe(MEM_ramwe), .WB_RW(WB_RW), .WB_regwe(WB_regwe),
    .ID_forwardA(ID_forwardA), .ID_forwardB(ID_forwardB),
    .EX_forwardA(EX_forwardA), .EX_forwardB(EX_forwardB), .MEM_forward(MEM_forward),
    .stall(stall), .flush_idex(flush_idex), .ex_hold(ex_hold), .mdu_done(mdu_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [RW-1:0] src, input logic [RW-1:0] mrw,
                                           input logic mwe, input logic [RW-1:0] wrw,
                                           input logic wwe);
    if (src == 0) return 2'b00;
    if (mwe && src == mrw) return 2'b10;
    if (wwe && src == wrw) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic id_reads(input logic [RW-1:0] r);
    return (r != 0) && ((ID_use_rs && ID_rs == r) || (ID_use_rt && ID_rt == r));
  endfunction

  // Reference model: a multicycle op accepted in cycle c stalls cycles c..c+L-2 and
  // releases in cycle c+L-1.
  int cyc = 0;
  int rel_cyc = -10;
  int m_stall = 0;
  int m_flush = 0;

  always @(negedge clk) begin
    logic hz, hold, rel, start, e_stall, e_flush, e_hold;
    int cmax;
    cmax = (1 << CNT_W) - 1;
    chk("ID_forwardA", ID_forwardA, fwd_model(ID_rs, MEM_RW, MEM_regwe, WB_RW, WB_regwe));
    chk("ID_forwardB", ID_forwardB, fwd_model(ID_rt, MEM_RW, MEM_regwe, WB_RW, WB_regwe));
    chk("EX_forwardA", EX_forwardA, fwd_model(EX_rs, MEM_RW, MEM_regwe, WB_RW, WB_regwe));
    chk("EX_forwardB", EX_forwardB, fwd_model(EX_rt, MEM_RW, MEM_regwe, WB_RW, WB_regwe));
    chk("MEM_forward", MEM_forward,
        WB_regwe && MEM_ramwe && MEM_rt != 0 && MEM_rt == WB_RW);
    if (!rst_n) begin
      rel_cyc = -10;
      m_stall = 0;
      m_flush = 0;
      chk("rst_stall", stall, 0);
      chk("rst_flush", flush_idex, 0);
      chk("rst_ex_hold", ex_hold, 0);
      chk("rst_mdu_done", mdu_done, 0);
      chk("rst_stall_cycles", stall_cycles, 0);
      chk("rst_flush_count", flush_count, 0);
    end else begin
      hz = (EX_memread && EX_regwe && id_reads(EX_RW)) ||
           (ID_is_branch && ((EX_regwe && id_reads(EX_RW)) || (MEM_memread && id_reads(MEM_RW))));
      hold    = cyc < rel_cyc;
      rel     = cyc == rel_cyc;
      start   = !hold && !rel && EX_mdu_start;
      e_stall = start || hold || hz;
      e_flush = !hold && hz;
      e_hold  = start || hold;
      chk("stall", stall, e_stall);
      chk("flush_idex", flush_idex, e_flush);
      chk("ex_hold", ex_hold, e_hold);
      chk("mdu_done", mdu_done, rel);
      chk("stall_cycles", stall_cycles, CNT_ON ? m_stall : 0);
      chk("flush_count", flush_count, CNT_ON ? m_flush : 0);
      if (start) rel_cyc = cyc + MDU_LAT - 1;
      if (e_stall && m_stall < cmax) m_stall++;
      if (e_flush && m_flush < cmax) m_flush++;
    end
    cyc++;
  end

  task automatic clr();
    {ID_rs, ID_rt, EX_rs, EX_rt, EX_RW, MEM_rt, MEM_RW, WB_RW} = '0;
    {ID_use_rs, ID_use_rt, ID_is_branch, EX_regwe, EX_memread, EX_mdu_start} = '0;
    {MEM_regwe, MEM_memread, MEM_ramwe, WB_regwe} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_8();
    EX_memread = 1; EX_regwe = 1; EX_RW = 8; ID_use_rt = 1; ID_rt = 8;
  endtask

  initial begin
    clr();
    EX_rs = 3; MEM_RW = 3; MEM_regwe = 1;
    step(); #1;
    chk("lit_rst_fwd_mem", EX_forwardA, 2'b10);
    chk("lit_rst_stall", stall, 0);
    chk("lit_rst_cnt", stall_cycles, 0);
    step(); rst_n = 1;

    // Forwarding priority and the register-0 exclusion
    step(); clr(); EX_rs = 3; MEM_RW = 3; MEM_regwe = 1; WB_RW = 3; WB_regwe = 1; #1;
    chk("lit_fwd_mem_wins", EX_forwardA, 2'b10);
    step(); EX_rs = 0; #1;
    chk("lit_fwd_r0", EX_forwardA, 2'b00);
    step(); EX_rs = 3; MEM_regwe = 0; MEM_ramwe = 1; MEM_rt = 3; ID_rt = 3; #1;
    chk("lit_fwd_wb", EX_forwardA, 2'b01);
    chk("lit_fwd_id_wb", ID_forwardB, 2'b01);
    chk("lit_mem_fwd", MEM_forward, 1);

    // Load-use, then the load moves to MEM and is forwarded
    step(); clr(); load_use_8(); #1;
    chk("lit_lu_stall", stall, 1);
    chk("lit_lu_flush", flush_idex, 1);
    step(); clr(); MEM_RW = 8; MEM_regwe = 1; MEM_memread = 1; EX_rt = 8; #1;
    chk("lit_lu_after_stall", stall, 0);
    chk("lit_lu_after_fwd", EX_forwardB, 2'b10);
    step(); clr(); EX_memread = 1; EX_regwe = 1; EX_RW = 0; ID_use_rt = 1; ID_rt = 0; #1;
    chk("lit_lu_r0", stall, 0);

    // Branch in ID waiting on a load in MEM
    step(); clr(); ID_is_branch = 1; ID_rs = 5; ID_use_rs = 1; MEM_memread = 1; MEM_RW = 5; #1;
    chk("lit_br_stall", stall, 1);
    chk("lit_br_flush", flush_idex, 1);
    step(); clr(); ID_is_branch = 1; ID_rs = 5; ID_use_rs = 1; EX_regwe = 1; EX_RW = 5;

    // Multicycle op with start held, then back-to-back start
    step(); clr(); EX_mdu_start = 1;
    for (int i = 0; i < MDU_LAT - 1; i++) begin
      if (i > 0) step();
      #1;
      chk("lit_mdu_stall", stall, 1);
      chk("lit_mdu_hold", ex_hold, 1);
    end
    step(); #1;
    chk("lit_mdu_rel_stall", stall, 0);
    chk("lit_mdu_done", mdu_done, 1);
    step(); #1;
    chk("lit_mdu_b2b_stall", stall, 1);
    chk("lit_mdu_b2b_done", mdu_done, 0);
    repeat (MDU_LAT - 1) step();
    clr();

    // Hazard suppressed while busy, honoured in the release cycle
    step(); EX_mdu_start = 1;
    step(); load_use_8(); #1;
    chk("lit_busy_noflush", flush_idex, 0);
    step();
    step(); #1;
    chk("lit_rel_haz_stall", stall, 1);
    chk("lit_rel_haz_flush", flush_idex, 1);
    chk("lit_rel_haz_done", mdu_done, 1);

    // Hazard and start together in IDLE
    step(); clr(); EX_mdu_start = 1; load_use_8(); #1;
    chk("lit_both_stall", stall, 1);
    chk("lit_both_flush", flush_idex, 1);
    chk("lit_both_hold", ex_hold, 1);
    step(); clr();
    repeat (MDU_LAT) step();

    // Reset during the second busy cycle
    step(); EX_mdu_start = 1;
    step();
    step(); #1;
    chk("lit_busy2_stall", stall, 1);
    rst_n = 0; #1;
    chk("lit_rstbusy_stall", stall, 0);
    chk("lit_rstbusy_hold", ex_hold, 0);
    chk("lit_rstbusy_cnt", stall_cycles, 0);
    chk("lit_rstbusy_fcnt", flush_count, 0);
    step(); rst_n = 1; EX_mdu_start = 0; #1;
    chk("lit_after_rst_stall", stall, 0);
    step(); #1;
    chk("lit_after_rst_cnt", stall_cycles, 0);

    // Twenty consecutive stalls saturate a 4-bit counter
    step(); clr(); load_use_8();
    repeat (19) step();
    step(); clr(); #1;
    chk("lit_sat_stall_cycles", stall_cycles, CNT_ON ? 15 : 0);
    chk("lit_sat_flush_count", flush_count, CNT_ON ? 15 : 0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
